// File: rtl/dram_burst_model.sv
// Behavioural DRAM burst model: serves burst read/write requests over the D_* handshake
// with configurable width, depth, address stride, read latency and injected back-pressure.
module dram_burst_model #(
   parameter int DRAMW        = 512,
   parameter int DEPTH        = 2**25,
   parameter int ADDR_STEP    = 8,
   parameter int READ_LAT     = 1,
   parameter int STALL_PERIOD = 0
) (
   input  logic             CLK,
   input  logic             RST_X,
   input  logic [1:0]       D_REQ,
   input  logic [31:0]      D_INITADR,
   input  logic [31:0]      D_ELEM,
   input  logic [DRAMW-1:0] D_DIN,
   output logic             D_W,
   output logic [DRAMW-1:0] D_DOUT,
   output logic             D_DOUTEN,
   output logic             D_BUSY,
   output logic             ERR,
   output logic [31:0]      RD_BEATS,
   output logic [31:0]      WR_BEATS
);

   localparam logic [1:0] REQ_READ  = 2'd1;
   localparam logic [1:0] REQ_WRITE = 2'd2;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_WRITE = 2'd1;
   localparam logic [1:0] ST_READ  = 2'd2;
   localparam logic [1:0] ST_DRAIN = 2'd3;

   localparam int IW = $clog2(DEPTH);
   localparam int SW = $clog2(ADDR_STEP);
   localparam int CW = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
   localparam logic [31:0]   STEP       = 32'(ADDR_STEP);
   localparam logic [31:0]   STEP_MASK  = 32'(ADDR_STEP - 1);
   localparam logic [31:0]   LAST_ADR   = 32'((DEPTH - 1) * ADDR_STEP);
   localparam logic [CW-1:0] CNT_LAST   = CW'((STALL_PERIOD > 0) ? STALL_PERIOD - 1 : 0);
   localparam logic [3:0]    DRAIN_INIT = 4'((READ_LAT > 1) ? READ_LAT - 2 : 0);

   logic [DRAMW-1:0]    mem_r [DEPTH];
   logic [1:0]          state_r, state_n;
   logic [31:0]         addr_r, addr_n, remain_r, remain_n, addr_inc_s;
   logic [CW-1:0]       cnt_r, cnt_n;
   logic [3:0]          drain_r, drain_n;
   logic                rdy_r, rdy_n, d_w_r, busy_r, err_r;
   logic                wr_pend_r;
   logic [IW-1:0]       wr_idx_r, blk_s;
   logic                accept_s, issue_s;
   logic [READ_LAT-1:0] pipe_v_r, pipe_v_n;
   logic [DRAMW-1:0]    pipe_d_r [READ_LAT];
   logic [31:0]         rd_beats_r, wr_beats_r;

   assign accept_s   = (state_r == ST_IDLE) && ((D_REQ == REQ_READ) || (D_REQ == REQ_WRITE))
                       && (D_ELEM != 32'd0);
   assign issue_s    = (state_r == ST_READ) && rdy_r;
   assign addr_inc_s = (addr_r == LAST_ADR) ? 32'd0 : addr_r + STEP;
   assign blk_s      = addr_r[SW +: IW];

   // Next-state, address/remain bookkeeping and the stall counter.
   always_comb begin
      state_n  = state_r;
      addr_n   = addr_r;
      remain_n = remain_r;
      drain_n  = drain_r;
      cnt_n    = '0;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               state_n  = (D_REQ == REQ_READ) ? ST_READ : ST_WRITE;
               addr_n   = D_INITADR & ~STEP_MASK;
               remain_n = D_ELEM;
            end else begin
               state_n = ST_IDLE;
            end
         end
         ST_WRITE, ST_READ: begin
            if ((STALL_PERIOD == 0) || (cnt_r == CNT_LAST)) begin
               cnt_n = '0;
            end else begin
               cnt_n = cnt_r + CW'(1);
            end
            if (rdy_r) begin
               addr_n   = addr_inc_s;
               remain_n = remain_r - 32'd1;
               if (remain_r == 32'd1) begin
                  drain_n = DRAIN_INIT;
                  // With one-cycle latency the last beat lands on the same edge, so skip DRAIN.
                  if ((state_r == ST_WRITE) || (READ_LAT == 1)) begin
                     state_n = ST_IDLE;
                  end else begin
                     state_n = ST_DRAIN;
                  end
               end else begin
                  state_n = state_r;
               end
            end else begin
               state_n = state_r;
            end
         end
         ST_DRAIN: begin
            if (drain_r == 4'd0) begin
               state_n = ST_IDLE;
            end else begin
               drain_n = drain_r - 4'd1;
            end
         end
         default: state_n = ST_IDLE;
      endcase
      rdy_n = ((state_n == ST_READ) || (state_n == ST_WRITE))
              && ((STALL_PERIOD == 0) || (cnt_n != CNT_LAST));
   end

   // Valid bits entering each read pipeline stage on the next edge.
   always_comb begin
      pipe_v_n    = '0;
      pipe_v_n[0] = issue_s;
      for (int i = 1; i < READ_LAT; i++) begin
         pipe_v_n[i] = pipe_v_r[i-1];
      end
   end

   // Control state, read pipeline, error flag and beat counters.
   always_ff @(posedge CLK or negedge RST_X) begin
      if (!RST_X) begin
         state_r    <= ST_IDLE;
         addr_r     <= 32'd0;
         remain_r   <= 32'd0;
         cnt_r      <= '0;
         drain_r    <= 4'd0;
         rdy_r      <= 1'b0;
         d_w_r      <= 1'b0;
         busy_r     <= 1'b0;
         err_r      <= 1'b0;
         wr_pend_r  <= 1'b0;
         wr_idx_r   <= '0;
         pipe_v_r   <= '0;
         rd_beats_r <= 32'd0;
         wr_beats_r <= 32'd0;
         for (int i = 0; i < READ_LAT; i++) begin
            pipe_d_r[i] <= '0;
         end
      end else begin
         state_r    <= state_n;
         addr_r     <= addr_n;
         remain_r   <= remain_n;
         cnt_r      <= cnt_n;
         drain_r    <= drain_n;
         rdy_r      <= rdy_n;
         d_w_r      <= (state_n == ST_WRITE) && rdy_n;
         busy_r     <= (state_n != ST_IDLE);
         err_r      <= err_r | (accept_s && ((D_INITADR & STEP_MASK) != 32'd0));
         wr_pend_r  <= (state_r == ST_WRITE) && rdy_r;
         wr_idx_r   <= blk_s;
         pipe_v_r   <= pipe_v_n;
         rd_beats_r <= rd_beats_r + {31'd0, pipe_v_n[READ_LAT-1]};
         wr_beats_r <= wr_beats_r + {31'd0, wr_pend_r};
         pipe_d_r[0] <= issue_s ? mem_r[blk_s] : '0;
         for (int i = 1; i < READ_LAT; i++) begin
            pipe_d_r[i] <= pipe_d_r[i-1];
         end
      end
   end

   // Storage array; data arrives the cycle after its grant and survives reset.
   always_ff @(posedge CLK) begin
      if (wr_pend_r) begin
         mem_r[wr_idx_r] <= D_DIN;
      end
   end

   assign D_W      = d_w_r;
   assign D_DOUT   = pipe_d_r[READ_LAT-1];
   assign D_DOUTEN = pipe_v_r[READ_LAT-1];
   assign D_BUSY   = busy_r;
   assign ERR      = err_r;
   assign RD_BEATS = rd_beats_r;
   assign WR_BEATS = wr_beats_r;

endmodule

// File: tb/tb_dram_burst_model.sv
// Directed bench for dram_burst_model: unit 0 is unstalled, 1-cycle latency, depth 16;
// unit 1 is 4-cycle latency with a ready drop every third transfer cycle.
module tb_dram_burst_model;

   logic        clk, rst_n;
   logic [1:0]  req_s   [2];
   logic [31:0] adr_s   [2];
   logic [31:0] elem_s  [2];
   logic [31:0] din_s   [2];
   logic        dw_s    [2];
   logic        douten_s[2];
   logic        busy_s  [2];
   logic        err_s   [2];
   logic [31:0] dout_s  [2];
   logic [31:0] rdb_s   [2];
   logic [31:0] wrb_s   [2];

   int          checks = 0;
   int          errors = 0;
   logic [31:0] rd_d [16];
   int          rd_k [16];

   dram_burst_model #(.DRAMW(32), .DEPTH(16), .ADDR_STEP(8), .READ_LAT(1), .STALL_PERIOD(0)) u0 (
      .CLK(clk), .RST_X(rst_n), .D_REQ(req_s[0]), .D_INITADR(adr_s[0]), .D_ELEM(elem_s[0]),
      .D_DIN(din_s[0]), .D_W(dw_s[0]), .D_DOUT(dout_s[0]), .D_DOUTEN(douten_s[0]),
      .D_BUSY(busy_s[0]), .ERR(err_s[0]), .RD_BEATS(rdb_s[0]), .WR_BEATS(wrb_s[0]));

   dram_burst_model #(.DRAMW(32), .DEPTH(16), .ADDR_STEP(8), .READ_LAT(4), .STALL_PERIOD(3)) u1 (
      .CLK(clk), .RST_X(rst_n), .D_REQ(req_s[1]), .D_INITADR(adr_s[1]), .D_ELEM(elem_s[1]),
      .D_DIN(din_s[1]), .D_W(dw_s[1]), .D_DOUT(dout_s[1]), .D_DOUTEN(douten_s[1]),
      .D_BUSY(busy_s[1]), .ERR(err_s[1]), .RD_BEATS(rdb_s[1]), .WR_BEATS(wrb_s[1]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset(input int u, input string tag);
      chk({tag, "_dw"}, {31'd0, dw_s[u]}, 32'd0);
      chk({tag, "_douten"}, {31'd0, douten_s[u]}, 32'd0);
      chk({tag, "_dout"}, dout_s[u], 32'd0);
      chk({tag, "_busy"}, {31'd0, busy_s[u]}, 32'd0);
      chk({tag, "_err"}, {31'd0, err_s[u]}, 32'd0);
      chk({tag, "_rdb"}, rdb_s[u], 32'd0);
      chk({tag, "_wrb"}, wrb_s[u], 32'd0);
   endtask

   // Called at a falling edge; returns at the falling edge of the first cycle after acceptance.
   task automatic issue_req(input int u, input logic [1:0] kind, input logic [31:0] a,
                            input logic [31:0] n);
      req_s[u]  = kind;
      adr_s[u]  = a;
      elem_s[u] = n;
      @(negedge clk);
      req_s[u] = 2'd0;
   endtask

   task automatic write_burst(input int u, input logic [31:0] a, input int n,
                              input logic [31:0] base, output int grants, output int first,
                              output int last, output int idle);
      int   j = 0;
      logic prev = 1'b0;
      grants = 0; first = -1; last = -1; idle = -1;
      issue_req(u, 2'd2, a, n);
      for (int k = 0; k < 60; k++) begin
         if (prev) begin
            din_s[u] = base + j;
            j++;
         end
         prev = dw_s[u];
         if (dw_s[u]) begin
            grants++;
            if (first < 0) first = k;
            last = k;
         end
         if (!busy_s[u]) begin
            idle = k;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic read_burst(input int u, input logic [31:0] a, input int n, input bit intrude,
                             output int beats, output int idle, output bit saw_dw);
      beats = 0; idle = -1; saw_dw = 1'b0;
      issue_req(u, 2'd1, a, n);
      for (int k = 0; k < 80; k++) begin
         if (intrude && k == 1) begin
            req_s[u] = 2'd2; adr_s[u] = 32'h0; elem_s[u] = 32'd2;
         end else if (intrude && k == 2) begin
            req_s[u] = 2'd0;
         end
         if (dw_s[u]) saw_dw = 1'b1;
         if (douten_s[u]) begin
            if (beats < 16) begin
               rd_d[beats] = dout_s[u];
               rd_k[beats] = k;
            end
            beats++;
         end
         if (!busy_s[u]) begin
            idle = k;
            break;
         end
         @(negedge clk);
      end
   endtask

   initial begin
      int   g, f, l, idle, nb;
      bit   sdw;
      logic prev;
      int   exp_k [6];
      exp_k = '{4, 5, 7, 8, 10, 11};
      rst_n = 1'b0;
      for (int u = 0; u < 2; u++) begin
         req_s[u] = 2'd0; adr_s[u] = 32'd0; elem_s[u] = 32'd0; din_s[u] = 32'd0;
      end
      #12;
      chk_reset(0, "rst0");
      chk_reset(1, "rst1");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Write 1..4 at 0x40, then read back in the first idle cycle.
      write_burst(0, 32'h40, 4, 32'd1, g, f, l, idle);
      chk("t1_grants", g, 32'd4);
      chk("t1_first", f, 32'd0);
      chk("t1_last", l, 32'd3);
      chk("t1_wr_idle", idle, 32'd4);
      read_burst(0, 32'h40, 4, 1'b0, nb, idle, sdw);
      chk("t1_beats", nb, 32'd4);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("t1_data%0d", i), rd_d[i], 32'(i + 1));
         chk($sformatf("t1_cyc%0d", i), rd_k[i], 32'(i + 1));
      end
      chk("t1_rd_idle", idle, 32'd4);
      chk("t1_rdb", rdb_s[0], 32'd4);
      chk("t1_wrb", wrb_s[0], 32'd4);

      // Wrap from LAST (block 15) to block 0.
      write_burst(0, 32'h78, 4, 32'hA, g, f, l, idle);
      chk("t2_grants", g, 32'd4);
      chk("t2_wr_idle", idle, 32'd4);
      read_burst(0, 32'h0, 2, 1'b0, nb, idle, sdw);
      chk("t2_beats", nb, 32'd2);
      chk("t2_data0", rd_d[0], 32'hB);
      chk("t2_data1", rd_d[1], 32'hC);
      read_burst(0, 32'h78, 1, 1'b0, nb, idle, sdw);
      chk("t2_blk15", rd_d[0], 32'hA);

      // Zero-length request is ignored.
      issue_req(0, 2'd2, 32'h0, 32'd0);
      chk("e0_busy_a", {31'd0, busy_s[0]}, 32'd0);
      @(negedge clk);
      chk("e0_busy_b", {31'd0, busy_s[0]}, 32'd0);
      chk("e0_dw", {31'd0, dw_s[0]}, 32'd0);

      // Write request during a read burst is dropped.
      read_burst(0, 32'h40, 4, 1'b1, nb, idle, sdw);
      chk("ei_beats", nb, 32'd4);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("ei_data%0d", i), rd_d[i], 32'(i + 1));
      end
      chk("ei_idle", idle, 32'd4);
      chk("ei_no_dw", {31'd0, sdw}, 32'd0);
      chk("ei_wrb", wrb_s[0], 32'd8);
      read_burst(0, 32'h0, 1, 1'b0, nb, idle, sdw);
      chk("ei_blk0", rd_d[0], 32'hB);

      // Misaligned start address.
      chk("ea_err_before", {31'd0, err_s[0]}, 32'd0);
      read_burst(0, 32'h44, 1, 1'b0, nb, idle, sdw);
      chk("ea_data", rd_d[0], 32'd1);
      chk("ea_err", {31'd0, err_s[0]}, 32'd1);
      chk("ea_rdb", rdb_s[0], 32'd13);

      // Reset after two committed beats of a five-block write.
      issue_req(0, 2'd2, 32'h40, 32'd5);
      prev = 1'b0;
      for (int k = 0; k < 3; k++) begin
         if (prev) din_s[0] = 32'h51 + 32'(k - 1);
         prev = dw_s[0];
         @(negedge clk);
      end
      chk("rw_wrb_pre", wrb_s[0], 32'd10);
      din_s[0] = 32'h53;
      rst_n = 1'b0;
      #1;
      chk_reset(0, "rw_async");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      read_burst(0, 32'h40, 3, 1'b0, nb, idle, sdw);
      chk("rw_beats", nb, 32'd3);
      chk("rw_data0", rd_d[0], 32'h51);
      chk("rw_data1", rd_d[1], 32'h52);
      chk("rw_data2", rd_d[2], 32'd3);
      chk("rw_rdb", rdb_s[0], 32'd3);
      chk("rw_wrb", wrb_s[0], 32'd0);

      // Latency 4, ready drops every third transfer cycle.
      write_burst(1, 32'h20, 6, 32'h61, g, f, l, idle);
      chk("s_grants", g, 32'd6);
      chk("s_first", f, 32'd0);
      chk("s_last", l, 32'd7);
      chk("s_wr_idle", idle, 32'd8);
      read_burst(1, 32'h20, 6, 1'b0, nb, idle, sdw);
      chk("s_beats", nb, 32'd6);
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("s_data%0d", i), rd_d[i], 32'h61 + 32'(i));
         chk($sformatf("s_cyc%0d", i), rd_k[i], 32'(exp_k[i]));
      end
      chk("s_rd_idle", idle, 32'd11);
      chk("s_rdb", rdb_s[1], 32'd6);
      chk("s_wrb", wrb_s[1], 32'd6);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed no finish expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/dram_burst_model.md
# dram_burst_model

Parametrised behavioural DRAM burst model for the sorter simulation benches. It sits between CORE and the bench top and serves CORE's burst read/write requests over the existing D_* handshake. It generalises the fixed single-cycle model to configurable data width, depth, address stride and read latency. It adds deterministic back-pressure injection, wrap-around and beat counters so the core's stall tolerance can be exercised.

## Interface
- DRAMW, 512: data width per block (bits).
- DEPTH, 2**25: number of blocks stored; power of two.
- ADDR_STEP, 8: byte-address increment per block; power of two.
- READ_LAT, 1: cycles from read issue to data (1..8).
- STALL_PERIOD, 0: 0 = never stall; N>0 = ready drops one cycle in every N transfer-state cycles.
- CLK  in  1  clock.
- RST_X  in  1  reset: one clock; asynchronous, active-low.
- D_REQ  in  2  request. `DRAM_REQ_READ or `DRAM_REQ_WRITE; any other value means no request.
- D_INITADR  in  32  initial byte address.
- D_ELEM  in  32  blocks in the burst.
- D_DIN  in  DRAMW  write data.
- D_W  out  1  write-beat grant.
- D_DOUT  out  DRAMW  read data.
- D_DOUTEN  out  1  read data valid.
- D_BUSY  out  1  a burst is in progress.
- ERR  out  1  sticky protocol error.
- RD_BEATS  out  32  read beats delivered since reset.
- WR_BEATS  out  32  write beats committed since reset.

## Operation
- States:
  - IDLE: accepts requests.
  - WRITE: write burst in progress.
  - READ: issues read addresses.
  - DRAIN: waits for outstanding read beats.
- IDLE accepts a request when D_REQ is READ/WRITE and D_ELEM != 0.
  - On accept: latch addr = D_INITADR, remain = D_ELEM; go to READ or WRITE.
  - A D_ELEM == 0 request is ignored and the state stays IDLE.
- ERR is set if an accepted D_INITADR is not a multiple of ADDR_STEP. The burst proceeds with the low bits masked.
- Block index = (addr / ADDR_STEP) mod DEPTH.
- Address advance: addr becomes 0 when addr == LAST = (DEPTH-1)*ADDR_STEP; otherwise addr + ADDR_STEP.
- rdy is an internal stall counter, active only in READ/WRITE.
  - It counts transfer-state cycles; rdy = 0 when the count reaches STALL_PERIOD-1, then the count returns to 0.
  - The counter resets to 0 on each accept.
- WRITE:
  - D_W = rdy.
  - Each D_W cycle advances addr and decrements remain.
  - The D_DIN presented in the cycle after a D_W cycle is written to the block that D_W granted.
  - When remain reaches 0, go to IDLE. The final data write still completes on the next edge.
- READ:
  - Each rdy cycle issues the current block into a READ_LAT-deep valid/data pipeline, advances addr and decrements issue-remain.
  - When the last block is issued, go to DRAIN.
  - The pipeline output drives D_DOUT/D_DOUTEN. RD_BEATS increments per D_DOUTEN.
- DRAIN: when the last beat leaves the pipeline, go to IDLE.
- D_BUSY = (state != IDLE).
- Requests presented while busy are ignored; they are not queued.
- Memory array is not cleared by reset.
- WR_BEATS increments per committed write. Both counters wrap at 2^32.

## Timing
- Reset values: D_W 0, D_DOUT 0, D_DOUTEN 0, D_BUSY 0, ERR 0, RD_BEATS 0, WR_BEATS 0; state IDLE; pipeline valids cleared.
- Reset asserted mid-burst aborts immediately. Any pending final write is dropped.
- Request sampled at edge E0:
  - D_BUSY is high from E0+ (the cycle after E0).
  - WRITE: first D_W is in cycle E0+ when rdy.
  - READ: first issue is in cycle E0+. With no stalls, D_DOUTEN goes high READ_LAT cycles after issue, i.e. first visible in cycle E0+READ_LAT+1.
- Unstalled throughput is one block per cycle in both directions.
- Write burst of n blocks, no stalls: D_W high for n consecutive cycles. D_BUSY falls on the edge ending the nth D_W cycle.
- Read burst of n blocks, no stalls: n consecutive D_DOUTEN cycles. D_BUSY drops on the edge that presents the last beat.
- A new request may be accepted in the first IDLE cycle. There is no dead cycle.
- A stall cycle shows D_W = 0 (WRITE) or a bubble in D_DOUTEN READ_LAT cycles later (READ).
- Read-after-write to the same block is coherent once the write's final data edge has passed.

## Test plan
- Write-then-read, defaults, STALL_PERIOD=0: write 4 blocks at 0x40 with data 1..4, then read 4 at 0x40.
  - Required: D_W high 4 consecutive cycles.
  - Required: D_DOUT = 1,2,3,4 on 4 consecutive D_DOUTEN cycles, first at request edge +2.
  - Required: RD_BEATS = WR_BEATS = 4.
- Wrap-around, DEPTH=16: write 4 blocks at LAST = 0x78 with data A,B,C,D; read 2 at 0x0.
  - Required: reads return B,C; block 15 holds A.
- READ_LAT=4, STALL_PERIOD=3, read 6 blocks.
  - Required: 6 D_DOUTEN beats in address order, with bubbles after every 2nd issue.
  - Required: first beat at request edge +5; D_BUSY low after the 6th.
- Protocol edge cases:
  - D_ELEM=0 request → D_BUSY stays 0.
  - Write request during a read burst → ignored; read completes unchanged.
  - D_INITADR=0x44 → ERR=1 and the burst starts at 0x40.
- Reset mid-write: RST_X low after 2 of 5 D_W beats.
  - Required: all outputs return to reset values asynchronously.
  - Required: the 2 committed blocks are preserved; the next request is accepted normally.
